and_input_driver: RTL and testbench

AND_INPUT_DRIVER -- requirements
Module: and_input_driver

---
 rtl/and_input_driver.sv | 206 ++++++++++++++++++++
 tb/tb_and_input_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_input_driver.sv
// -----------------------------------------------------------------------------
// and_input_driver
//
// Stimulus driver for a combinational AND-gate under test. Operand pairs are
// queued in a small FIFO and then presented to the gate one at a time. Each
// presentation lasts one cycle and is marked by a strobe. The expected gate
// output is presented alongside the operands. An optional number of idle
// cycles can be inserted between consecutive presentations.
//
// Parameters
//   DATA_WIDTH  : operand width
//   FIFO_DEPTH  : queued pair capacity (power of 2, 2..16)
//   IDLE_CYCLES : idle cycles after each drive (0..15)
//
// Ports
//   clock      in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   operand pair offered
//   req_ready  out  FIFO can accept a pair
//   req_a/b    in   offered operands
//   flush      in   synchronous abort: empty FIFO, return to IDLE
//   and_a/b    out  operands driven to the AND gate (zero outside DRIVE)
//   and_en     out  one-cycle drive strobe
//   exp_y      out  expected gate output, and_a & and_b (zero outside DRIVE)
//   busy       out  FSM not idle or FIFO non-empty
//   txn_count  out  completed drives, wraps at 16 bits
// -----------------------------------------------------------------------------
module and_input_driver #(
  parameter int DATA_WIDTH  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] and_a,
  output logic [DATA_WIDTH-1:0] and_b,
  output logic                  and_en,
  output logic [DATA_WIDTH-1:0] exp_y,
  output logic                  busy,
  output logic [15:0]           txn_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit NO_GAP = (IDLE_CYCLES == 0);
  localparam logic [3:0] GAP_LOAD = (IDLE_CYCLES > 0) ? 4'(IDLE_CYCLES - 1) : 4'd0;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  state_t                  state_reg;
  logic [AW:0]             wr_ptr_reg;
  logic [AW:0]             rd_ptr_reg;
  logic [3:0]              gap_reg;
  logic                    ready_en_reg;
  logic                    and_en_reg;
  logic [DATA_WIDTH-1:0]   and_a_reg;
  logic [DATA_WIDTH-1:0]   and_b_reg;
  logic [DATA_WIDTH-1:0]   exp_y_reg;
  logic [15:0]             txn_count_reg;

  // Pair storage: {a, b}. No reset so the array can map onto RAM.
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic [2*DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0]   head_a;
  logic [DATA_WIDTH-1:0]   head_b;
  logic [DATA_WIDTH-1:0]   head_y;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // ready_en_reg holds ready low through reset and until the first edge after
  // release. Since ready is low while full, a full FIFO never pushes, even when
  // the same edge pops.
  assign req_ready = ready_en_reg && !fifo_full && !flush;
  assign push      = req_valid && req_ready;

  assign head   = mem[rd_ptr_reg[AW-1:0]];
  assign head_a = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_b = head[DATA_WIDTH-1:0];

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_exp
    assign head_y[gi] = head_a[gi] & head_b[gi];
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {req_a, req_b};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      gap_reg       <= '0;
      ready_en_reg  <= 1'b0;
      and_en_reg    <= 1'b0;
      and_a_reg     <= '0;
      and_b_reg     <= '0;
      exp_y_reg     <= '0;
      txn_count_reg <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      // Drive outputs default to zero; only a pop below raises them.
      and_en_reg   <= 1'b0;
      and_a_reg    <= '0;
      and_b_reg    <= '0;
      exp_y_reg    <= '0;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end

      case (state_reg)
        ST_IDLE: begin
          if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            gap_reg    <= '0;
          end else if (!fifo_empty) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            and_en_reg <= 1'b1;
            and_a_reg  <= head_a;
            and_b_reg  <= head_b;
            exp_y_reg  <= head_y;
            state_reg  <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          // The strobe in flight always completes and is counted, flush or not.
          txn_count_reg <= txn_count_reg + 16'd1;
          if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            gap_reg    <= '0;
            state_reg  <= ST_IDLE;
          end else if (NO_GAP) begin
            if (!fifo_empty) begin
              rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
              and_en_reg <= 1'b1;
              and_a_reg  <= head_a;
              and_b_reg  <= head_b;
              exp_y_reg  <= head_y;
              state_reg  <= ST_DRIVE;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            gap_reg   <= GAP_LOAD;
            state_reg <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            gap_reg    <= '0;
            state_reg  <= ST_IDLE;
          end else if (gap_reg == 4'd0) begin
            if (!fifo_empty) begin
              rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
              and_en_reg <= 1'b1;
              and_a_reg  <= head_a;
              and_b_reg  <= head_b;
              exp_y_reg  <= head_y;
              state_reg  <= ST_DRIVE;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            gap_reg <= gap_reg - 4'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign and_en    = and_en_reg;
  assign and_a     = and_a_reg;
  assign and_b     = and_b_reg;
  assign exp_y     = exp_y_reg;
  assign txn_count = txn_count_reg;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_and_input_driver.sv
// -----------------------------------------------------------------------------
// tb_and_input_driver
//
// Two instances share one clock: u_dut0 has no idle gap, and u_dut1 has three
// idle cycles per drive. Both instances are 4 bits wide with a depth of 4.
// Strobes are captured by a monitor into queues. These queues are then
// compared against hand-computed vector tables.
// -----------------------------------------------------------------------------
module tb_and_input_driver;

  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  logic          rst0_n, v0, rdy0, fl0, en0, busy0;
  logic [DW-1:0] a0, b0, ea0, eb0, y0;
  logic [15:0]   cnt0;
  logic          rst1_n, v1, rdy1, fl1, en1, busy1;
  logic [DW-1:0] a1, b1, ea1, eb1, y1;
  logic [15:0]   cnt1;

  and_input_driver #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .IDLE_CYCLES(0)) u_dut0 (
    .clock(clk), .reset_n(rst0_n), .req_valid(v0), .req_ready(rdy0),
    .req_a(a0), .req_b(b0), .flush(fl0), .and_a(ea0), .and_b(eb0),
    .and_en(en0), .exp_y(y0), .busy(busy0), .txn_count(cnt0)
  );

  and_input_driver #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .IDLE_CYCLES(3)) u_dut1 (
    .clock(clk), .reset_n(rst1_n), .req_valid(v1), .req_ready(rdy1),
    .req_a(a1), .req_b(b1), .flush(fl1), .and_a(ea1), .and_b(eb1),
    .and_en(en1), .exp_y(y1), .busy(busy1), .txn_count(cnt1)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
  } vec_t;

  vec_t vecs_b2b [6];
  vec_t vecs_gap [6];

  logic [3*DW-1:0] q0[$];
  logic [3*DW-1:0] q1[$];
  int              t0[$];
  int              t1[$];
  bit              rec0 = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Capture strobes, and check that the drive outputs are zero between strobes.
  always @(posedge clk) begin
    #1;
    if (en0 === 1'b1) begin
      if (rec0) begin
        q0.push_back({ea0, eb0, y0});
        t0.push_back(cycle);
      end
    end else begin
      check("idle_zero0", {20'd0, ea0, eb0, y0}, 32'd0);
    end
    if (en1 === 1'b1) begin
      q1.push_back({ea1, eb1, y1});
      t1.push_back(cycle);
    end else begin
      check("idle_zero1", {20'd0, ea1, eb1, y1}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle0(input int budget);
    int n = 0;
    while (busy0 && n < budget) begin
      step();
      n++;
    end
    check("idle0_timeout", busy0, 0);
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    while (busy1 && n < budget) begin
      step();
      n++;
    end
    check("idle1_timeout", busy1, 0);
  endtask

  initial begin
    vecs_b2b[0] = '{4'hF, 4'h3, 4'h3};
    vecs_b2b[1] = '{4'hA, 4'hC, 4'h8};
    vecs_b2b[2] = '{4'h5, 4'h5, 4'h5};
    vecs_b2b[3] = '{4'h0, 4'hF, 4'h0};
    vecs_b2b[4] = '{4'hF, 4'hF, 4'hF};
    vecs_b2b[5] = '{4'h6, 4'h3, 4'h2};
    vecs_gap[0] = '{4'h1, 4'hF, 4'h1};
    vecs_gap[1] = '{4'h2, 4'h7, 4'h2};
    vecs_gap[2] = '{4'hC, 4'hA, 4'h8};
    vecs_gap[3] = '{4'h9, 4'h3, 4'h1};
    vecs_gap[4] = '{4'h6, 4'hE, 4'h6};
    vecs_gap[5] = '{4'hF, 4'h0, 4'h0};

    rst0_n = 1'b0; rst1_n = 1'b0;
    v0 = 0; a0 = '0; b0 = '0; fl0 = 0;
    v1 = 0; a1 = '0; b1 = '0; fl1 = 0;

    // ---- reset state ----
    step();
    check("rst_en0", en0, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_rdy0", rdy0, 0);
    check("rst_rdy1", rdy1, 0);
    step();
    rst0_n = 1'b1; rst1_n = 1'b1;
    #1;
    check("rdy0_before_edge", rdy0, 0);
    step();
    check("rdy0_after_edge", rdy0, 1);
    check("rdy1_after_edge", rdy1, 1);

    // ---- single pair, latency ----
    q0.delete(); t0.delete();
    v0 = 1; a0 = 4'h1; b0 = 4'h1;
    step();
    v0 = 0;
    check("single_no_strobe_yet", en0, 0);
    check("single_busy", busy0, 1);
    step();
    check("single_en", en0, 1);
    check("single_y", y0, 4'h1);
    check("single_a", ea0, 4'h1);
    check("single_cnt_during", cnt0, 0);
    step();
    check("single_en_off", en0, 0);
    check("single_cnt", cnt0, 1);
    check("single_busy_off", busy0, 0);

    // ---- back-to-back table (no gap) ----
    q0.delete(); t0.delete();
    for (int i = 0; i < 6; i++) begin
      v0 = 1; a0 = vecs_b2b[i].a; b0 = vecs_b2b[i].b;
      check("b2b_ready", rdy0, 1);
      step();
    end
    v0 = 0;
    wait_idle0(50);
    check("b2b_count_strobes", q0.size(), 6);
    if (q0.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("b2b_data%0d", i), q0[i], {vecs_b2b[i].a, vecs_b2b[i].b, vecs_b2b[i].y});
        check($sformatf("b2b_spacing%0d", i), t0[i] - t0[0], i);
      end
    end
    check("b2b_txn", cnt0, 7);

    // ---- full FIFO with gap of 3 ----
    q1.delete(); t1.delete();
    begin
      int acc = 0;
      int first_low = -1;
      int n = 0;
      while (acc < 6 && n < 60) begin
        logic took;
        v1 = 1; a1 = vecs_gap[acc].a; b1 = vecs_gap[acc].b;
        took = rdy1;
        step();
        n++;
        if (took) acc++;
        else if (first_low < 0) first_low = acc;
      end
      v1 = 0;
      check("full_accepts", acc, 6);
      check("full_ready_low_after", first_low, 5);
    end
    wait_idle1(60);
    check("gap_count_strobes", q1.size(), 6);
    if (q1.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("gap_data%0d", i), q1[i], {vecs_gap[i].a, vecs_gap[i].b, vecs_gap[i].y});
        if (i > 0) check($sformatf("gap_spacing%0d", i), t1[i] - t1[i-1], 4);
      end
    end
    check("gap_txn", cnt1, 6);

    // ---- flush mid-gap ----
    rst1_n = 1'b0;
    #1;
    rst1_n = 1'b1;
    step();
    q1.delete(); t1.delete();
    for (int i = 0; i < 3; i++) begin
      v1 = 1; a1 = vecs_gap[i].a; b1 = vecs_gap[i].b;
      step();
    end
    // First pair strobed, now in GAP with two pairs still queued.
    check("flush_in_gap_en", en1, 0);
    check("flush_in_gap_busy", busy1, 1);
    v1 = 1; a1 = 4'h7; b1 = 4'h7; fl1 = 1;
    #1;
    check("flush_blocks_ready", rdy1, 0);
    step();
    fl1 = 0; v1 = 0;
    check("flush_busy_off", busy1, 0);
    check("flush_cnt", cnt1, 1);
    repeat (10) step();
    check("flush_no_more_strobes", q1.size(), 1);
    check("flush_cnt_later", cnt1, 1);

    // ---- async reset mid-drive ----
    v0 = 1; a0 = 4'hF; b0 = 4'h9;
    step();
    v0 = 0;
    step();
    check("arst_driving", en0, 1);
    #1;
    rst0_n = 1'b0;
    #1;
    check("arst_en", en0, 0);
    check("arst_cnt", cnt0, 0);
    check("arst_rdy", rdy0, 0);
    check("arst_busy", busy0, 0);
    check("arst_a", ea0, 0);
    #1;
    rst0_n = 1'b1;
    step();
    check("arst_rdy_back", rdy0, 1);
    v0 = 1; a0 = 4'h6; b0 = 4'h3;
    step();
    v0 = 0;
    step();
    check("arst_new_en", en0, 1);
    check("arst_new_y", y0, 4'h2);
    step();
    check("arst_new_cnt", cnt0, 1);

    // ---- txn_count wrap ----
    rst0_n = 1'b0;
    #1;
    rst0_n = 1'b1;
    step();
    rec0 = 1'b0;
    begin
      int acc = 0;
      int n = 0;
      v0 = 1; a0 = 4'hF; b0 = 4'hF;
      while (acc < 65535 && n < 70000) begin
        if (rdy0) acc++;
        step();
        n++;
      end
      v0 = 0;
      check("wrap_accepts", acc, 65535);
    end
    wait_idle0(20);
    check("wrap_cnt_ffff", cnt0, 16'hFFFF);
    v0 = 1; a0 = 4'h3; b0 = 4'h1;
    step();
    v0 = 0;
    wait_idle0(10);
    check("wrap_cnt_zero", cnt0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
